// File: rtl/mem_copy_engine.sv
// Word-wise copy / fill DMA engine driving the s1 port of a single-port on-chip RAM.
// Programmed through a 4-register control slave; irq reports completion.
module mem_copy_engine #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ctl_address,
    input  logic              ctl_read,
    input  logic              ctl_write,
    input  logic [31:0]       ctl_writedata,
    output logic [31:0]       ctl_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state_q, state_d;

    logic [31:0]       src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              mode_q, mode_d, ie_q, done_q, aborted_q;
    logic [31:0]       wdata_q, rd_mux;
    logic              wr_copy_q;
    logic              idle, busy, ctrl_wr, start_req, abort_req, clear_req;
    logic              abort_hit, done_set;

    assign idle      = (state_q == IDLE);
    assign busy      = !idle;
    assign ctrl_wr   = ctl_write && (ctl_address == 2'd0);
    assign abort_req = ctrl_wr && ctl_writedata[3];
    assign start_req = ctrl_wr && ctl_writedata[0] && !ctl_writedata[3] && idle;
    assign clear_req = ctrl_wr && ctl_writedata[4];
    assign abort_hit = abort_req && busy;
    // mode only changes while idle, so during a transfer mode_q is the latched mode
    assign mode_d    = (idle && ctrl_wr) ? ctl_writedata[1] : mode_q;
    assign done_set  = ((state_q == DONE) || (start_req && (len_q == '0))) && !abort_hit;

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        case (state_q)
            IDLE: begin
                if (start_req && (len_q != '0)) begin
                    state_d   = ctl_writedata[1] ? WR : RD;
                    src_ptr_d = src_q[ADDR_W-1:0];
                    dst_ptr_d = dst_q;
                    rem_d     = len_q;
                end
            end
            RD:   state_d = WR;
            WR: begin
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                rem_d     = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = DONE;
                else if (!mode_q)       state_d = RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = IDLE;

        addr_d = '0;
        if (state_d == RD)      addr_d = src_ptr_d;
        else if (state_d == WR) addr_d = dst_ptr_d;
    end

    always_comb begin
        case (ctl_address)
            2'd0:    rd_mux = {27'd0, mode_q, ie_q, aborted_q, done_q, busy};
            2'd1:    rd_mux = mode_q ? src_q : 32'(src_q[ADDR_W-1:0]);
            2'd2:    rd_mux = 32'(dst_q);
            default: rd_mux = 32'(len_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            irq          <= 1'b0;
            ctl_readdata <= '0;
        end else begin
            mode_q <= mode_d;
            if (ctrl_wr) ie_q <= ctl_writedata[2];
            if (idle && ctl_write) begin
                case (ctl_address)
                    2'd1:    src_q <= ctl_writedata;
                    2'd2:    dst_q <= ctl_writedata[ADDR_W-1:0];
                    2'd3:    len_q <= ctl_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (done_set)       done_q <= 1'b1;
            else if (clear_req) done_q <= 1'b0;
            if (abort_hit)      aborted_q <= 1'b1;
            else if (clear_req) aborted_q <= 1'b0;
            irq <= done_q & ie_q;
            if (ctl_read) ctl_readdata <= rd_mux;
        end
    end

    // Bus outputs are registered from the next state so each RD/WR appears in its own state cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            wr_copy_q      <= 1'b0;
            wdata_q        <= '0;
        end else begin
            mem_chipselect <= (state_d == RD) || (state_d == WR);
            mem_write      <= (state_d == WR);
            mem_address    <= addr_d;
            wr_copy_q      <= (state_d == WR) && !mode_d;
            wdata_q        <= ((state_d == WR) && mode_d) ? src_q : '0;
        end
    end

    // Copy data comes straight from the read issued in the preceding RD cycle.
    assign mem_writedata  = wr_copy_q ? mem_readdata : wdata_q;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural 32K x 32 RAM plus an array-level reference of
// what each copy/fill should leave in memory.
module tb_mem_copy_engine;
    localparam int ADDR_W    = 15;
    localparam int LEN_W     = 16;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        ctl_address = '0;
    logic              ctl_read = 1'b0;
    logic              ctl_write = 1'b0;
    logic [31:0]       ctl_writedata = '0;
    logic [31:0]       ctl_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata = '0;
    logic              irq;

    logic [31:0] mem  [MEM_WORDS];
    logic [31:0] refm [MEM_WORDS];
    logic        mem_init = 1'b1;
    logic        poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          cs_count = 0;
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_copy_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .ctl_address(ctl_address), .ctl_read(ctl_read), .ctl_write(ctl_write),
        .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_chipselect) begin
            cs_count <= cs_count + 1;
            if (mem_write) begin
                mem[mem_address] <= mem_writedata;
                wr_count <= wr_count + 1;
            end
            mem_readdata <= mem[mem_address];
        end
    end

    task automatic poke(input int addr, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1;
        poke_addr = ADDR_W'(addr % MEM_WORDS);
        poke_data = data;
        refm[addr % MEM_WORDS] = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic ctl_wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        ctl_address = addr;
        ctl_writedata = data;
        ctl_write = 1'b1;
        @(negedge clk);
        ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        ctl_address = addr;
        ctl_read = 1'b1;
        @(negedge clk);
        ctl_read = 1'b0;
        data = ctl_readdata;
    endtask

    task automatic ref_copy(input int src, input int dst, input int len);
        for (int i = 0; i < len; i++)
            refm[(dst + i) % MEM_WORDS] = refm[(src + i) % MEM_WORDS];
    endtask

    task automatic ref_fill(input logic [31:0] pat, input int dst, input int len);
        for (int i = 0; i < len; i++) refm[(dst + i) % MEM_WORDS] = pat;
    endtask

    task automatic mem_diff(output int nd, output int first);
        nd = 0;
        first = -1;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== refm[i]) begin
                nd++;
                if (first < 0) first = i;
            end
    endtask

    // Programs a transfer with ie=1, starts it and counts cycles until irq (-1 on timeout).
    task automatic run_op(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                          input int len, output int n, output int cs, output int wr);
        int c0, w0;
        bit got;
        ctl_wr(2'd1, src);
        ctl_wr(2'd2, dst);
        ctl_wr(2'd3, 32'(len));
        ctl_wr(2'd0, 32'h14 | (32'(mode) << 1));
        c0 = cs_count;
        w0 = wr_count;
        @(negedge clk);
        ctl_address = 2'd0;
        ctl_writedata = 32'h05 | (32'(mode) << 1);
        ctl_write = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 2000) begin
            @(negedge clk);
            ctl_write = 1'b0;
            n++;
            if (irq) got = 1;
        end
        if (!got) n = -1;
        cs = cs_count - c0;
        wr = wr_count - w0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        n_checks++; if (ctl_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %0h expected 0", ctl_readdata); end
        n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %0b expected 0", mem_chipselect); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %0b expected 0", mem_write); end
        n_checks++; if (mem_address !== '0) begin n_fail++; $display("FAIL reset_address: got %0h expected 0", mem_address); end
        n_checks++; if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", mem_writedata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        n_checks++; if (mem_byteenable !== 4'hF) begin n_fail++; $display("FAIL byteenable: got %0h expected f", mem_byteenable); end
        n_checks++; if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL clken: got %0b expected 1", mem_clken); end
        for (int a = 0; a < 4; a++) begin
            ctl_rd(2'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %0h expected 0", a, rd); end
        end
    endtask

    task automatic test_copy;
        int n, cs, wr, nd, first;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) poke(16'h10 + i, 32'hA0 + 32'(i));
        run_op(1'b0, 32'h10, 32'h100, 4, n, cs, wr);
        ref_copy(16'h10, 16'h100, 4);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL copy_latency: got %0d expected 11", n); end
        n_checks++; if (cs !== 8) begin n_fail++; $display("FAIL copy_mem_cycles: got %0d expected 8", cs); end
        n_checks++; if (wr !== 4) begin n_fail++; $display("FAIL copy_writes: got %0d expected 4", wr); end
        mem_diff(nd, first);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL copy_memory: %0d words differ, first %0h got %0h expected %0h", nd, first, mem[first], refm[first]); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h0A) begin n_fail++; $display("FAIL copy_status: got %0h expected a", rd); end
        ctl_rd(2'd1, rd);
        n_checks++; if (rd !== 32'h10) begin n_fail++; $display("FAIL copy_src_kept: got %0h expected 10", rd); end
        ctl_rd(2'd2, rd);
        n_checks++; if (rd !== 32'h100) begin n_fail++; $display("FAIL copy_dst_kept: got %0h expected 100", rd); end
        ctl_rd(2'd3, rd);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL copy_len_kept: got %0h expected 4", rd); end
    endtask

    task automatic test_fill_wrap;
        int n, cs, wr, nd, first;
        logic [31:0] rd;
        poke(1, 32'h1234_5678);
        run_op(1'b1, 32'hDEAD_BEEF, 32'h7FFE, 3, n, cs, wr);
        ref_fill(32'hDEAD_BEEF, 16'h7FFE, 3);
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL fill_latency: got %0d expected 6", n); end
        n_checks++; if (cs !== 3) begin n_fail++; $display("FAIL fill_mem_cycles: got %0d expected 3", cs); end
        n_checks++; if (mem[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fill_wrap_word0: got %0h expected deadbeef", mem[0]); end
        n_checks++; if (mem[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL fill_word1_untouched: got %0h expected 12345678", mem[1]); end
        mem_diff(nd, first);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL fill_memory: %0d words differ, first %0h got %0h expected %0h", nd, first, mem[first], refm[first]); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h1A) begin n_fail++; $display("FAIL fill_status: got %0h expected 1a", rd); end
        ctl_rd(2'd1, rd);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fill_pattern_kept: got %0h expected deadbeef", rd); end
    endtask

    task automatic test_len0_irq;
        int n, cs, wr;
        logic [31:0] rd;
        run_op(1'b0, 32'h40, 32'h50, 0, n, cs, wr);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL len0_latency: got %0d expected 2", n); end
        n_checks++; if (cs !== 0) begin n_fail++; $display("FAIL len0_no_access: got %0d expected 0", cs); end
        ctl_wr(2'd0, 32'h14);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_after_clear: got %0b expected 1", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall_after_clear: got %0b expected 0", irq); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h08) begin n_fail++; $display("FAIL clear_status: got %0h expected 8", rd); end
        run_op(1'b0, 32'h40, 32'h50, 0, n, cs, wr);
        ctl_wr(2'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall_after_ie0: got %0b expected 0", irq); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h02) begin n_fail++; $display("FAIL ie0_status: got %0h expected 2", rd); end
    endtask

    task automatic test_overlap;
        int n, cs, wr;
        for (int i = 0; i < 4; i++) poke(16'h20 + i, 32'(i + 1));
        run_op(1'b0, 32'h20, 32'h21, 3, n, cs, wr);
        ref_copy(16'h20, 16'h21, 3);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL overlap_latency: got %0d expected 9", n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h20 + i] !== 32'h1) begin n_fail++; $display("FAIL overlap_word%0d: got %0h expected 1", i, mem[16'h20 + i]); end
        end
    endtask

    task automatic test_abort;
        int w0, w, c0, nd, first;
        logic [31:0] rd;
        ctl_wr(2'd1, 32'h1000);
        ctl_wr(2'd2, 32'h2000);
        ctl_wr(2'd3, 32'd100);
        ctl_wr(2'd0, 32'h14);
        w0 = wr_count;
        ctl_wr(2'd0, 32'h05);
        ctl_wr(2'd2, 32'h3000);
        repeat (16) @(negedge clk);
        ctl_wr(2'd0, 32'h0C);
        w = wr_count - w0;
        repeat (5) @(negedge clk);
        n_checks++; if (w < 9 || w > 11) begin n_fail++; $display("FAIL abort_word_count: got %0d expected 9..11", w); end
        n_checks++; if (wr_count - w0 !== w) begin n_fail++; $display("FAIL abort_writes_stop: got %0d expected %0d", wr_count - w0, w); end
        ref_copy(16'h1000, 16'h2000, w);
        mem_diff(nd, first);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL abort_memory: %0d words differ, first %0h got %0h expected %0h", nd, first, mem[first], refm[first]); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h0C) begin n_fail++; $display("FAIL abort_status: got %0h expected c", rd); end
        ctl_rd(2'd2, rd);
        n_checks++; if (rd !== 32'h2000) begin n_fail++; $display("FAIL busy_dst_write_ignored: got %0h expected 2000", rd); end
        ctl_wr(2'd0, 32'h10);
        c0 = cs_count;
        ctl_wr(2'd0, 32'h09);
        repeat (3) @(negedge clk);
        n_checks++; if (cs_count - c0 !== 0) begin n_fail++; $display("FAIL start_abort_no_access: got %0d expected 0", cs_count - c0); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL start_abort_status: got %0h expected 0", rd); end
    endtask

    task automatic test_random;
        int n, cs, wr, nd, first, len, exp_n, exp_cs;
        int src, dst;
        logic mode;
        logic [31:0] pat;
        for (int it = 0; it < 6; it++) begin
            mode = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 24);
            src  = (it == 2) ? 32'h7FF8 : $urandom_range(0, MEM_WORDS - 1);
            dst  = (it % 2 == 1) ? (src + $urandom_range(0, 30)) % MEM_WORDS
                                 : $urandom_range(0, MEM_WORDS - 1);
            pat  = $urandom;
            if (!mode) begin
                for (int i = 0; i < len; i++) poke(src + i, $urandom);
                run_op(1'b0, 32'(src), 32'(dst), len, n, cs, wr);
                ref_copy(src, dst, len);
                exp_n  = 2 * len + 3;
                exp_cs = 2 * len;
            end else begin
                run_op(1'b1, pat, 32'(dst), len, n, cs, wr);
                ref_fill(pat, dst, len);
                exp_n  = len + 3;
                exp_cs = len;
            end
            n_checks++; if (n !== exp_n) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, n, exp_n); end
            n_checks++; if (cs !== exp_cs) begin n_fail++; $display("FAIL rand%0d_mem_cycles: got %0d expected %0d", it, cs, exp_cs); end
            mem_diff(nd, first);
            n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL rand%0d_memory: %0d words differ, first %0h got %0h expected %0h", it, nd, first, mem[first], refm[first]); end
        end
    endtask

    task automatic test_reset_mid;
        int w0, w, nd, first;
        logic [31:0] rd;
        ctl_wr(2'd1, 32'hCAFE_F00D);
        ctl_wr(2'd2, 32'h4000);
        ctl_wr(2'd3, 32'd50);
        ctl_wr(2'd0, 32'h16);
        w0 = wr_count;
        ctl_wr(2'd0, 32'h07);
        repeat (3) @(negedge clk);
        n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL mid_in_wr: got %0b expected 1", mem_write); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL async_write_drop: got %0b expected 0", mem_write); end
        n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL async_cs_drop: got %0b expected 0", mem_chipselect); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        w = wr_count - w0;
        repeat (10) @(negedge clk);
        n_checks++; if (w !== 3) begin n_fail++; $display("FAIL mid_words_before_reset: got %0d expected 3", w); end
        n_checks++; if (wr_count - w0 !== w) begin n_fail++; $display("FAIL no_write_after_reset: got %0d expected %0d", wr_count - w0, w); end
        ref_fill(32'hCAFE_F00D, 16'h4000, w);
        mem_diff(nd, first);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL mid_memory: %0d words differ, first %0h got %0h expected %0h", nd, first, mem[first], refm[first]); end
        ctl_rd(2'd0, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL status_after_reset: got %0h expected 0", rd); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) refm[i] = init_val(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        test_reset;
        test_copy;
        test_fill_wrap;
        test_len0_irq;
        test_overlap;
        test_abort;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
